imm_extend_unit: RTL
====================

Name: imm_extend_unit

Overview:
- Registered, parametrised immediate-extension stage between the decoder and the ALU operand mux of the RISC datapath; successor to the fixed 7-to-16 combinational sign extender.
- Supports four modes: sign-extend, zero-extend, shift-left (upper-immediate), and prefix.
- Prefix instructions accumulate upper bits across cycles so a following instruction can form a full DATA_W constant.
- One-cycle latency, with stall and flush handling that matches the pipeline.

Parameters:
- IMM_W, 7: width of the instruction immediate field.
- DATA_W, 16: datapath and result width. Legal range IMM_W < DATA_W.
- SHIFT, 9: left-shift amount for mode 2. Legal range 0 <= SHIFT < DATA_W.
- PRE_W: derived, DATA_W-IMM_W. Width of the prefix register. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoder presents a valid immediate this cycle.
- immediate  in  IMM_W  raw immediate field.
- mode  in  2  00 sign-extend, 01 zero-extend, 10 shift-left, 11 prefix.
- stall  in  1  pipeline hold. Outputs and internal state freeze.
- flush  in  1  squash in-flight result and any pending prefix.
- out_valid  out  1  ext_immediate is valid.
- ext_immediate  out  DATA_W  extended result.
- prefix_pending  out  1  prefix register holds unconsumed bits.

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, ext_immediate=0, prefix_pending=0.
  - Prefix register = 0.
  - Reset mid-prefix discards the accumulated bits.
- Priority per rising edge: flush > stall > normal.
- flush=1:
  - Next cycle out_valid=0, prefix_pending=0, prefix register=0.
  - ext_immediate holds its previous value.
  - in_valid is ignored that cycle.
- stall=1 (no flush):
  - All registers hold, including out_valid.
  - in_valid is ignored; upstream re-presents the instruction.
- Normal cycle, in_valid=0: out_valid<=0, ext_immediate holds, prefix state unchanged.
- Normal cycle, in_valid=1, mode=11 (prefix):
  - prefix <= ((prefix << IMM_W) | zero-extended immediate), truncated to PRE_W.
  - prefix_pending <= 1, out_valid <= 0.
  - Back-to-back prefixes chain; excess upper bits drop silently.
- Normal cycle, in_valid=1, mode!=11, prefix_pending=1:
  - ext_immediate <= {prefix, immediate}. The mode field is ignored.
  - out_valid <= 1.
  - prefix <= 0, prefix_pending <= 0.
- Normal cycle, in_valid=1, prefix_pending=0:
  - mode 00: ext_immediate <= immediate replicated-MSB to DATA_W.
  - mode 01: ext_immediate <= immediate zero-padded to DATA_W.
  - mode 10: ext_immediate <= (zero-extended immediate) << SHIFT, truncated to DATA_W.
  - out_valid <= 1.
- Latency: exactly 1 cycle from the accepting edge to out_valid/ext_immediate, when not stalled.
- Throughput: one non-prefix immediate per cycle.
- All arithmetic is unsigned bit manipulation; no overflow flag.

Test Plan:
1. Extension modes (IMM_W=7, DATA_W=16, SHIFT=9), in_valid=1 for one cycle each; result appears one edge later with out_valid=1:
   - mode 00, imm 7'b1000000 -> 16'hFFC0.
   - mode 00, imm 7'b0111111 -> 16'h003F.
   - mode 01, imm 7'b1000000 -> 16'h0040.
   - mode 10, imm 7'h7F -> 16'hFE00.
   - mode 00, imm 7'h00 -> 16'h0000.
2. Single and chained prefix:
   - mode 11 imm 7'h05, then mode 00 imm 7'h12 -> prefix_pending=1 after the first edge, out_valid=0 that cycle; then 16'h0292, out_valid=1, prefix_pending=0.
   - Prefixes 7'h01 then 7'h7F, then imm 7'h00 -> 16'h7F80.
3. Stall: mode 00 imm 7'h40 accepted, then stall=1 for 3 cycles with different immediates presented -> ext_immediate stays 16'hFFC0 and out_valid stays 1 throughout; prefix_pending is unchanged.
4. Flush:
   - Prefix 7'h05, then flush=1 with stall=1, then mode 01 imm 7'h12 -> prefix_pending=0 after the flush, result 16'h0012 (prefix discarded).
   - Flush during a valid output -> out_valid=0 next cycle.
5. Async reset: assert rst_n=0 mid-cycle while prefix_pending=1 and out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; the first post-reset immediate 7'h12 in mode 00 gives 16'h0012.
6. Parameter sweep: IMM_W=12, DATA_W=32, SHIFT=20; mode 00 imm 12'h800 -> 32'hFFFFF800; mode 10 imm 12'hABC -> 32'hABC00000.

Source files
------------

// File: rtl/imm_extend_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_unit_if
// Purpose  : Decoder-side request and ALU-side result bundle for the
//            immediate-extension stage.
// Revision : 1.0  initial release
// ============================================================================
interface imm_extend_unit_if #(
    parameter int IMM_W  = 7,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [IMM_W-1:0]  immediate;
    logic [1:0]        mode;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] ext_immediate;
    logic              prefix_pending;

    modport master (
        output in_valid, immediate, mode, stall, flush,
        input  out_valid, ext_immediate, prefix_pending
    );

    modport slave (
        input  in_valid, immediate, mode, stall, flush,
        output out_valid, ext_immediate, prefix_pending
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_unit
// Purpose  : Registered sign/zero/shift/prefix immediate extender feeding the
//            ALU operand mux, with pipeline stall and flush.
// Revision : 1.0  initial release
// ============================================================================
module imm_extend_unit #(
    parameter int IMM_W  = 7,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 9
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    imm_extend_unit_if.slave   bus
);
    localparam int         PRE_W       = DATA_W - IMM_W;
    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_SHL    = 2'b10;
    localparam logic [1:0] MODE_PREFIX = 2'b11;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_q, ext_d;
    logic [PRE_W-1:0]  prefix_q, prefix_d;
    logic              pending_q, pending_d;

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_shl;
    logic [DATA_W-1:0] w_concat;

    assign w_sext   = {{PRE_W{bus.immediate[IMM_W-1]}}, bus.immediate};
    assign w_zext   = {{PRE_W{1'b0}}, bus.immediate};
    assign w_shl    = w_zext << SHIFT;
    // Shifting the prefix up by IMM_W and truncating is just the low bits of the concat.
    assign w_concat = {prefix_q, bus.immediate};

    always_comb begin
        out_valid_d = out_valid_q;
        ext_d       = ext_q;
        prefix_d    = prefix_q;
        pending_d   = pending_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
            prefix_d    = '0;
            pending_d   = 1'b0;
        end else if (!bus.stall) begin
            out_valid_d = 1'b0;
            if (bus.in_valid) begin
                if (bus.mode == MODE_PREFIX) begin
                    prefix_d  = w_concat[PRE_W-1:0];
                    pending_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    prefix_d    = '0;
                    pending_d   = 1'b0;
                    if (pending_q) begin
                        ext_d = w_concat;
                    end else begin
                        case (bus.mode)
                            MODE_SEXT: ext_d = w_sext;
                            MODE_ZEXT: ext_d = w_zext;
                            MODE_SHL:  ext_d = w_shl;
                            default:   ext_d = w_zext;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ext_q       <= '0;
            prefix_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ext_q       <= ext_d;
            prefix_q    <= prefix_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.ext_immediate  = ext_q;
    assign bus.prefix_pending = pending_q;
endmodule
`default_nettype wire
